// File: rtl/game_sequencer.sv
`default_nettype none
// game_sequencer: phase/turn controller that places ships and arbitrates alternating shots on the board matrix.
// Rev 1.0 - initial release
module game_sequencer #(
  parameter int SHIPS    = 4,
  parameter int TURN_TMO = 650_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       host_click,
  input  logic [6:0] host_pos,
  input  logic       guest_click,
  input  logic [6:0] guest_pos,
  input  logic [1:0] cell_code,
  output logic [1:0] phase,
  output logic       tgt_sel,
  output logic [6:0] tgt_pos,
  output logic       place,
  output logic       turn,
  output logic [3:0] hits_host,
  output logic [3:0] hits_guest,
  output logic       shot_valid,
  output logic       shot_hit,
  output logic       game_over,
  output logic       winner
);

  localparam int               TMR_W      = (TURN_TMO > 1) ? $clog2(TURN_TMO) : 1;
  localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TURN_TMO - 1);
  localparam logic [3:0]       SHIPS_N    = 4'(SHIPS);
  localparam logic [6:0]       LAST_CELL  = 7'd99;
  localparam logic [1:0]       PH_SHOOT   = 2'b00;
  localparam logic [1:0]       PH_HOST    = 2'b01;
  localparam logic [1:0]       PH_GUEST   = 2'b10;
  localparam logic [1:0]       PH_IDLE    = 2'b11;
  localparam logic [1:0]       CODE_EMPTY = 2'b00;
  localparam logic [1:0]       CODE_SHIP  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_PLACE_H, S_PLACE_G, S_SHOOT, S_LOOKUP, S_RESOLVE, S_OVER
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             tgt_sel_q, tgt_sel_d;
  logic [6:0]       tgt_pos_q, tgt_pos_d;
  logic             place_q, place_d;
  logic             turn_q, turn_d;
  logic [3:0]       hits_host_q, hits_host_d;
  logic [3:0]       hits_guest_q, hits_guest_d;
  logic             shot_valid_q, shot_valid_d;
  logic             shot_hit_q, shot_hit_d;
  logic             game_over_q, game_over_d;
  logic             winner_q, winner_d;
  logic [3:0]       count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic       host_ok, guest_ok, shot_click;
  logic [6:0] shot_pos;
  logic [3:0] count_inc, score_q, score_inc;

  assign host_ok    = host_click && (host_pos <= LAST_CELL);
  assign guest_ok   = guest_click && (guest_pos <= LAST_CELL);
  assign shot_click = turn_q ? guest_ok : host_ok;
  assign shot_pos   = turn_q ? guest_pos : host_pos;
  assign count_inc  = count_q + 4'd1;
  assign score_q    = turn_q ? hits_guest_q : hits_host_q;
  assign score_inc  = (score_q >= SHIPS_N) ? score_q : score_q + 4'd1;

  // phase and tgt_sel follow the current state one cycle late, so during the place
  // strobe they still describe the cell being written, not the state being entered.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    tgt_sel_d    = tgt_sel_q;
    tgt_pos_d    = tgt_pos_q;
    place_d      = 1'b0;
    turn_d       = turn_q;
    hits_host_d  = hits_host_q;
    hits_guest_d = hits_guest_q;
    shot_valid_d = 1'b0;
    shot_hit_d   = shot_hit_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    count_d      = count_q;
    timer_d      = timer_q;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        phase_d = PH_IDLE;
        if (start_btn) begin
          state_d      = S_PLACE_H;
          hits_host_d  = 4'd0;
          hits_guest_d = 4'd0;
          count_d      = 4'd0;
          turn_d       = 1'b0;
          game_over_d  = 1'b0;
          timer_d      = '0;
        end
      end
      S_PLACE_H: begin
        phase_d   = PH_HOST;
        tgt_sel_d = 1'b0;
        if (host_ok) begin
          tgt_pos_d = host_pos;
          state_d   = S_LOOKUP;
        end
      end
      S_PLACE_G: begin
        phase_d   = PH_GUEST;
        tgt_sel_d = 1'b1;
        if (guest_ok) begin
          tgt_pos_d = guest_pos;
          state_d   = S_LOOKUP;
        end
      end
      S_SHOOT: begin
        phase_d   = PH_SHOOT;
        tgt_sel_d = ~turn_q;
        if (shot_click) begin
          tgt_pos_d = shot_pos;
          state_d   = S_LOOKUP;
        end else if (timer_q == TMO_LAST) begin
          turn_d  = ~turn_q;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_LOOKUP: state_d = S_RESOLVE;
      S_RESOLVE: begin
        if (phase_q != PH_SHOOT) begin
          state_d = (phase_q == PH_HOST) ? S_PLACE_H : S_PLACE_G;
          if (cell_code == CODE_EMPTY) begin
            place_d = 1'b1;
            if (count_inc == SHIPS_N) begin
              count_d = 4'd0;
              timer_d = '0;
              state_d = (phase_q == PH_HOST) ? S_PLACE_G : S_SHOOT;
            end else begin
              count_d = count_inc;
            end
          end
        end else begin
          state_d = S_SHOOT;
          if (cell_code == CODE_SHIP) begin
            place_d      = 1'b1;
            shot_valid_d = 1'b1;
            shot_hit_d   = 1'b1;
            timer_d      = '0;
            if (turn_q) hits_guest_d = score_inc;
            else        hits_host_d  = score_inc;
            if (score_inc == SHIPS_N) begin
              state_d     = S_OVER;
              game_over_d = 1'b1;
              winner_d    = turn_q;
            end
          end else if (cell_code == CODE_EMPTY) begin
            place_d      = 1'b1;
            shot_valid_d = 1'b1;
            shot_hit_d   = 1'b0;
            timer_d      = '0;
            turn_d       = ~turn_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_IDLE;
      tgt_sel_q    <= 1'b0;
      tgt_pos_q    <= 7'd0;
      place_q      <= 1'b0;
      turn_q       <= 1'b0;
      hits_host_q  <= 4'd0;
      hits_guest_q <= 4'd0;
      shot_valid_q <= 1'b0;
      shot_hit_q   <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      count_q      <= 4'd0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      tgt_sel_q    <= tgt_sel_d;
      tgt_pos_q    <= tgt_pos_d;
      place_q      <= place_d;
      turn_q       <= turn_d;
      hits_host_q  <= hits_host_d;
      hits_guest_q <= hits_guest_d;
      shot_valid_q <= shot_valid_d;
      shot_hit_q   <= shot_hit_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
    end
  end

  assign phase      = phase_q;
  assign tgt_sel    = tgt_sel_q;
  assign tgt_pos    = tgt_pos_q;
  assign place      = place_q;
  assign turn       = turn_q;
  assign hits_host  = hits_host_q;
  assign hits_guest = hits_guest_q;
  assign shot_valid = shot_valid_q;
  assign shot_hit   = shot_hit_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// tb_game_sequencer: randomized bench with a board matrix and a game-rule model.
// Rev 1.0 - initial release
module tb_game_sequencer;
  localparam int SHIPS    = 4;
  localparam int TURN_TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       host_click = 1'b0;
  logic       guest_click = 1'b0;
  logic [6:0] host_pos = 7'd0;
  logic [6:0] guest_pos = 7'd0;
  logic [1:0] cell_code;
  logic [1:0] phase;
  logic       tgt_sel, place, turn, shot_valid, shot_hit, game_over, winner;
  logic [6:0] tgt_pos;
  logic [3:0] hits_host, hits_guest;

  always #5 clk = ~clk;

  game_sequencer #(.SHIPS(SHIPS), .TURN_TMO(TURN_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn),
    .host_click(host_click), .host_pos(host_pos),
    .guest_click(guest_click), .guest_pos(guest_pos),
    .cell_code(cell_code), .phase(phase), .tgt_sel(tgt_sel), .tgt_pos(tgt_pos),
    .place(place), .turn(turn), .hits_host(hits_host), .hits_guest(hits_guest),
    .shot_valid(shot_valid), .shot_hit(shot_hit), .game_over(game_over), .winner(winner)
  );

  // Board matrix: registered read, writes on place according to the phase.
  logic [1:0] board [2][100];
  logic       clr_board = 1'b0;
  int         n_place = 0;

  always @(posedge clk) begin
    if (tgt_pos < 7'd100) cell_code <= board[tgt_sel][tgt_pos];
    else                  cell_code <= 2'b00;
    if (clr_board) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 100; c++) board[b][c] <= 2'b00;
    end else if (place && tgt_pos < 7'd100) begin
      if (phase != 2'b00)                         board[tgt_sel][tgt_pos] <= 2'b01;
      else if (board[tgt_sel][tgt_pos] == 2'b01)  board[tgt_sel][tgt_pos] <= 2'b10;
      else                                        board[tgt_sel][tgt_pos] <= 2'b11;
    end
  end

  always @(negedge clk) if (place === 1'b1) n_place++;

  // Game model: 0 idle, 1 host placing, 2 guest placing, 3 shooting, 4 over.
  int         m_st, m_count;
  bit         m_turn, m_winner;
  int         m_hits [2];
  logic [1:0] mboard [2][100];
  bit         e_place, e_sv, e_hit, e_sel;
  int         e_pos;
  logic       o_early, o_place, o_sv, o_hit, o_sel;
  logic [6:0] o_pos;
  int         checks = 0, errors = 0;

  function automatic logic [1:0] exp_phase();
    case (m_st)
      1: return 2'b01;
      2: return 2'b10;
      3: return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  function automatic int pick_cell(input int b, input int lo, input int hi);
    int s = $urandom_range(0, 99);
    for (int i = 0; i < 100; i++) begin
      int c = (s + i) % 100;
      if (mboard[b][c] >= 2'(lo) && mboard[b][c] <= 2'(hi)) return c;
    end
    return 127;
  endfunction

  task automatic model_clear(input int st);
    m_st = st; m_count = 0; m_turn = 0; m_hits[0] = 0; m_hits[1] = 0;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 100; c++) mboard[b][c] = 2'b00;
  endtask

  task automatic start_game();
    clr_board = 1'b1;
    @(negedge clk) clr_board = 1'b0;
    start_btn = 1'b1;
    @(negedge clk) start_btn = 1'b0;
    @(negedge clk);
    model_clear(1);
  endtask

  // One click cycle; predicts the outcome, then samples the strobe cycle and one cycle beyond.
  task automatic act(input bit h, input bit g, input logic [6:0] hp, input logic [6:0] gp);
    bit active = 1'b0;
    int pos = 0, b = 0;
    logic [1:0] code;
    case (m_st)
      1: begin active = h && hp <= 7'd99; pos = int'(hp); b = 0; end
      2: begin active = g && gp <= 7'd99; pos = int'(gp); b = 1; end
      3: if (!m_turn) begin active = h && hp <= 7'd99; pos = int'(hp); b = 1; end
         else         begin active = g && gp <= 7'd99; pos = int'(gp); b = 0; end
      default: ;
    endcase
    e_place = 1'b0; e_sv = 1'b0; e_pos = pos; e_sel = b[0];
    code = active ? mboard[b][pos] : 2'b11;
    if (active && m_st != 3) begin
      if (code == 2'b00) begin
        e_place = 1'b1; mboard[b][pos] = 2'b01; m_count++;
        if (m_count == SHIPS) begin m_count = 0; m_st++; end
      end
    end else if (active) begin
      if (code == 2'b01) begin
        e_place = 1'b1; e_sv = 1'b1; e_hit = 1'b1; mboard[b][pos] = 2'b10;
        m_hits[m_turn]++;
        if (m_hits[m_turn] == SHIPS) begin m_st = 4; m_winner = m_turn; end
      end else if (code == 2'b00) begin
        e_place = 1'b1; e_sv = 1'b1; e_hit = 1'b0; mboard[b][pos] = 2'b11;
        m_turn = ~m_turn;
      end
    end
    host_click = h; guest_click = g; host_pos = hp; guest_pos = gp;
    @(negedge clk) begin host_click = 1'b0; guest_click = 1'b0; end
    @(negedge clk) o_early = place | shot_valid;
    @(negedge clk) begin
      o_place = place; o_sv = shot_valid; o_hit = shot_hit; o_pos = tgt_pos; o_sel = tgt_sel;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [26:0] exp_v = {2'b11, 1'b0, 7'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [26:0] obs_v;
    rst_n = 1'b0; clr_board = 1'b1;
    repeat (3) @(negedge clk);
    clr_board = 1'b0;
    obs_v = {phase, tgt_sel, tgt_pos, place, turn, hits_host, hits_guest, shot_valid, shot_hit, game_over, winner};
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs_v, exp_v); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (phase !== 2'b11) begin errors++; $display("FAIL idle_phase: got %b expected 11", phase); end
    model_clear(0);
  endtask

  task automatic test_place_host();
    int seq [6] = '{0, 11, 11, 120, 22, 33};
    start_game();
    checks++;
    if (phase !== 2'b01) begin errors++; $display("FAIL start_phase: got %b expected 01", phase); end
    foreach (seq[i]) begin
      act(1'b1, 1'b0, 7'(seq[i]), 7'd0);
      checks++;
      if (o_place !== e_place || o_early !== 1'b0) begin
        errors++; $display("FAIL host_place[%0d]: got place=%b early=%b expected %b/0", i, o_place, o_early, e_place);
      end
      checks++;
      if (e_place && o_pos !== 7'(e_pos)) begin errors++; $display("FAIL host_pos[%0d]: got %0d expected %0d", i, o_pos, e_pos); end
      checks++;
      if (phase !== exp_phase()) begin errors++; $display("FAIL host_phase[%0d]: got %b expected %b", i, phase, exp_phase()); end
    end
  endtask

  task automatic test_place_guest();
    for (int n = 0; n < 80 && m_st == 2; n++) begin
      int gp = (n == 0) ? 5 : int'($urandom_range(0, 99));
      act($urandom_range(0, 1) == 1, 1'b1, 7'($urandom_range(0, 99)), 7'(gp));
      checks++;
      if (o_place !== e_place || (e_place && (o_pos !== 7'(e_pos) || o_sel !== 1'b1))) begin
        errors++; $display("FAIL guest_place[%0d]: got place=%b pos=%0d expected %b pos=%0d", n, o_place, o_pos, e_place, e_pos);
      end
    end
    checks++;
    if (phase !== 2'b00 || turn !== 1'b0) begin
      errors++; $display("FAIL enter_shoot: got phase=%b turn=%b expected 00/0", phase, turn);
    end
  endtask

  task automatic test_shoot_hit();
    act(1'b1, 1'b0, 7'd5, 7'd0);
    checks++;
    if (o_early !== 1'b0 || o_place !== 1'b1 || o_sv !== 1'b1 || o_hit !== 1'b1) begin
      errors++; $display("FAIL shot_hit: got early=%b place=%b valid=%b hit=%b expected 0/1/1/1", o_early, o_place, o_sv, o_hit);
    end
    checks++;
    if (hits_host !== 4'd1 || turn !== 1'b0 || o_sel !== 1'b1) begin
      errors++; $display("FAIL hit_score: got hits=%0d turn=%b sel=%b expected 1/0/1", hits_host, turn, o_sel);
    end
  endtask

  task automatic test_shoot_miss_simul();
    act(1'b1, 1'b0, 7'(pick_cell(1, 0, 0)), 7'd0);
    checks++;
    if (o_place !== 1'b1 || o_sv !== 1'b1 || o_hit !== 1'b0 || turn !== 1'b1) begin
      errors++; $display("FAIL shot_miss: got place=%b valid=%b hit=%b turn=%b expected 1/1/0/1", o_place, o_sv, o_hit, turn);
    end
    act(1'b1, 1'b0, 7'(pick_cell(1, 0, 1)), 7'd0);
    checks++;
    if (o_place !== 1'b0 || turn !== 1'b1) begin
      errors++; $display("FAIL inactive_click: got place=%b turn=%b expected 0/1", o_place, turn);
    end
    act(1'b1, 1'b1, 7'(pick_cell(1, 0, 1)), 7'(pick_cell(0, 0, 0)));
    checks++;
    if (o_place !== 1'b1 || o_pos !== 7'(e_pos) || o_sel !== 1'b0 || turn !== 1'b0) begin
      errors++; $display("FAIL simul_click: got place=%b pos=%0d sel=%b turn=%b expected 1/%0d/0/0", o_place, o_pos, o_sel, turn, e_pos);
    end
  endtask

  task automatic test_timeout();
    int p0 = n_place;
    // act already spent one idle shooting cycle after the resolving edge
    repeat (TURN_TMO - 2) @(negedge clk);
    checks++;
    if (turn !== m_turn) begin errors++; $display("FAIL tmo_early: got turn=%b expected %b", turn, m_turn); end
    @(negedge clk);
    m_turn = ~m_turn;
    checks++;
    if (turn !== m_turn || n_place != p0) begin
      errors++; $display("FAIL tmo_pass: got turn=%b places=%0d expected %b/%0d", turn, n_place, m_turn, p0);
    end
    act(1'b0, 1'b1, 7'd0, 7'(pick_cell(0, 0, 0)));
    checks++;
    if (o_place !== 1'b1 || o_sv !== 1'b1 || turn !== m_turn) begin
      errors++; $display("FAIL tmo_guest_shot: got place=%b valid=%b turn=%b expected 1/1/%b", o_place, o_sv, turn, m_turn);
    end
  endtask

  task automatic test_host_wins();
    for (int n = 0; n < 20 && m_st == 3; n++) begin
      if (!m_turn) act(1'b1, 1'b0, 7'(pick_cell(1, 1, 1)), 7'd0);
      else         act(1'b0, 1'b1, 7'd0, 7'(pick_cell(0, 0, 0)));
      checks++;
      if (o_place !== e_place || hits_host !== 4'(m_hits[0]) || hits_guest !== 4'(m_hits[1])) begin
        errors++; $display("FAIL win_run[%0d]: got place=%b hits=%0d/%0d expected %b %0d/%0d",
                           n, o_place, hits_host, hits_guest, e_place, m_hits[0], m_hits[1]);
      end
    end
    checks++;
    if (game_over !== 1'b1 || winner !== 1'b0 || phase !== 2'b11 || m_st != 4) begin
      errors++; $display("FAIL host_win: got over=%b winner=%b phase=%b expected 1/0/11", game_over, winner, phase);
    end
    start_game();
    checks++;
    if (phase !== 2'b01 || hits_host !== 4'd0 || hits_guest !== 4'd0 || game_over !== 1'b0) begin
      errors++; $display("FAIL restart: got phase=%b hits=%0d/%0d over=%b expected 01 0/0 0", phase, hits_host, hits_guest, game_over);
    end
  endtask

  task automatic test_reset_midgame();
    act(1'b1, 1'b0, 7'd42, 7'd0);
    checks++;
    if (o_place !== 1'b1) begin errors++; $display("FAIL pre_reset_place: got %b expected 1", o_place); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({phase, place, turn, game_over, tgt_pos} !== {2'b11, 1'b0, 1'b0, 1'b0, 7'd0}) begin
      errors++; $display("FAIL async_reset: got phase=%b place=%b pos=%0d expected 11/0/0", phase, place, tgt_pos);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    model_clear(0);
    m_winner = 1'b0; e_hit = 1'b0;
  endtask

  task automatic test_random_game();
    int streak = 0;
    start_game();
    for (int n = 0; n < 300 && m_st < 3; n++) begin
      int p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 99));
      if (m_st == 1) act(1'b1, 1'b0, 7'(p), 7'd0);
      else           act(1'b0, 1'b1, 7'd0, 7'(p));
      checks++;
      if (o_place !== e_place || phase !== exp_phase()) begin
        errors++; $display("FAIL rnd_place[%0d]: got place=%b phase=%b expected %b/%b", n, o_place, phase, e_place, exp_phase());
      end
    end
    for (int n = 0; n < 500 && m_st == 3; n++) begin
      int b = m_turn ? 0 : 1;
      int c = (streak < 2 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 99)) : pick_cell(b, 0, 1);
      bit both = ($urandom_range(0, 3) == 0);
      logic [6:0] other = 7'($urandom_range(0, 99));
      if (!m_turn) act(1'b1, both, 7'(c), other);
      else         act(both, 1'b1, other, 7'(c));
      streak = e_sv ? 0 : streak + 1;
      checks++;
      if (o_place !== e_place || o_sv !== e_sv || o_hit !== e_hit || (e_place && o_pos !== 7'(e_pos))) begin
        errors++; $display("FAIL rnd_shot[%0d]: got place=%b valid=%b hit=%b pos=%0d expected %b/%b/%b/%0d",
                           n, o_place, o_sv, o_hit, o_pos, e_place, e_sv, e_hit, e_pos);
      end
      checks++;
      if (turn !== m_turn || hits_host !== 4'(m_hits[0]) || hits_guest !== 4'(m_hits[1])) begin
        errors++; $display("FAIL rnd_state[%0d]: got turn=%b hits=%0d/%0d expected %b %0d/%0d",
                           n, turn, hits_host, hits_guest, m_turn, m_hits[0], m_hits[1]);
      end
    end
    checks++;
    if (m_st != 4 || game_over !== 1'b1 || winner !== m_winner || phase !== 2'b11) begin
      errors++; $display("FAIL rnd_over: got over=%b winner=%b phase=%b expected 1/%b/11", game_over, winner, phase, m_winner);
    end
  endtask

  initial begin
    m_winner = 1'b0; e_hit = 1'b0;
    test_reset();
    test_place_host();
    test_place_guest();
    test_shoot_hit();
    test_shoot_miss_simul();
    test_timeout();
    test_host_wins();
    test_reset_midgame();
    test_random_game();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
